// File: rtl/spiflash_cache_pkg.sv
// spiflash_cache_pkg: shared types, address width and field-width helpers for the flash line cache.
package spiflash_cache_pkg;
    localparam int ADDR_W = 24;
    typedef enum logic [1:0] {IDLE, FILL, RESP} state_e;
    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction
    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction
    function automatic int tag_w(input int lines, input int line_words);
        return ADDR_W - 2 - $clog2(lines) - $clog2(line_words);
    endfunction
endpackage

// File: rtl/spiflash_cache_ram.sv
// spiflash_cache_ram: simple dual-port 32-bit data array, synchronous write and synchronous read.
module spiflash_cache_ram #(
    parameter int DEPTH = 64,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/spiflash_cache.sv
// spiflash_cache: read-only direct-mapped line cache in front of spimemio.
// Define SPIFLASH_CACHE_INSTR_ONLY_EN to let data reads (cpu_instr=0) bypass the cache.
module spiflash_cache
    import spiflash_cache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              cpu_valid,
    input  logic              cpu_instr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [3:0]        cpu_wstrb,
    output logic              cpu_ready,
    output logic [31:0]       cpu_rdata,
    output logic              flash_valid,
    output logic [ADDR_W-1:0] flash_addr,
    input  logic              flash_ready,
    input  logic [31:0]       flash_rdata
);
    localparam int OB = off_w(LINE_WORDS);
    localparam int IB = idx_w(LINES);
    localparam int TB = tag_w(LINES, LINE_WORDS);

    state_e                 state_q, state_d;
    logic [LINES-1:0]       valid_q, valid_d;
    logic [LINES-1:0][TB-1:0] tag_q, tag_d;
    logic [ADDR_W-3:0]      addr_q, addr_d;
    logic [OB-1:0]          cnt_q, cnt_d;
    logic                   flushed_q, flushed_d, bypass_q, bypass_d;
    logic                   ready_q, ready_d, hit_q, hit_d, fvalid_q, fvalid_d;
    logic [ADDR_W-1:0]      faddr_q, faddr_d;
    logic [31:0]            word_q, word_d, rdata_q, rdata_d, ram_rdata;

    logic [IB-1:0] c_idx, idx;
    logic [TB-1:0] c_tag, tag;
    logic          c_bypass, fill_last, capture, unused;

    assign c_idx = cpu_addr[2+OB +: IB];
    assign c_tag = cpu_addr[ADDR_W-1 -: TB];
    assign idx = addr_q[OB +: IB];
    assign tag = addr_q[ADDR_W-3 -: TB];
    assign fill_last = bypass_q || cnt_q == '1;
    assign capture = bypass_q || cnt_q == addr_q[OB-1:0];
    assign unused = ^{cpu_addr[1:0], cpu_instr};
`ifdef SPIFLASH_CACHE_INSTR_ONLY_EN
    assign c_bypass = !cpu_instr;
`else
    assign c_bypass = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        valid_d = flush ? '0 : valid_q;
        tag_d = tag_q;
        addr_d = addr_q;
        cnt_d = cnt_q;
        flushed_d = flushed_q | flush;
        bypass_d = bypass_q;
        ready_d = 1'b0;
        hit_d = 1'b0;
        fvalid_d = fvalid_q;
        faddr_d = faddr_q;
        word_d = word_q;
        rdata_d = '0;
        case (state_q)
            IDLE: if (cpu_valid && !ready_q) begin
                if (|cpu_wstrb) begin
                    ready_d = 1'b1;
                end else if (!c_bypass && !flush && valid_q[c_idx] && tag_q[c_idx] == c_tag) begin
                    ready_d = 1'b1;
                    hit_d = 1'b1;
                end else begin
                    state_d = FILL;
                    addr_d = cpu_addr[ADDR_W-1:2];
                    cnt_d = '0;
                    flushed_d = 1'b0;
                    bypass_d = c_bypass;
                    fvalid_d = 1'b1;
                    faddr_d = c_bypass ? {cpu_addr[ADDR_W-1:2], 2'b00}
                                       : {cpu_addr[ADDR_W-1:2+OB], {OB{1'b0}}, 2'b00};
                end
            end
            FILL: if (fvalid_q && flash_ready) begin
                fvalid_d = 1'b0;
                cnt_d = cnt_q + OB'(1);
                faddr_d = {addr_q[ADDR_W-3:OB], cnt_q + OB'(1), 2'b00};
                if (capture) word_d = flash_rdata;
                if (fill_last) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    rdata_d = capture ? flash_rdata : word_q;
                    // A flush seen at any point of the fill leaves the line invalid.
                    if (!bypass_q && !flushed_d) begin
                        valid_d[idx] = 1'b1;
                        tag_d[idx] = tag;
                    end
                end
            end else if (!fvalid_q) begin
                fvalid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            valid_q <= '0;
            tag_q <= '0;
            addr_q <= '0;
            cnt_q <= '0;
            flushed_q <= 1'b0;
            bypass_q <= 1'b0;
            ready_q <= 1'b0;
            hit_q <= 1'b0;
            fvalid_q <= 1'b0;
            faddr_q <= '0;
            word_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            tag_q <= tag_d;
            addr_q <= addr_d;
            cnt_q <= cnt_d;
            flushed_q <= flushed_d;
            bypass_q <= bypass_d;
            ready_q <= ready_d;
            hit_q <= hit_d;
            fvalid_q <= fvalid_d;
            faddr_q <= faddr_d;
            word_q <= word_d;
            rdata_q <= rdata_d;
        end
    end

    // Hit data comes straight from the array's read register, loaded on the accepting edge.
    spiflash_cache_ram #(.DEPTH(LINES * LINE_WORDS), .AW(IB + OB)) u_ram (
        .clk(clk),
        .we(state_q == FILL && fvalid_q && flash_ready && !bypass_q),
        .waddr({idx, cnt_q}),
        .wdata(flash_rdata),
        .raddr(cpu_addr[2 +: IB+OB]),
        .rdata(ram_rdata)
    );

    assign cpu_ready = ready_q;
    assign cpu_rdata = hit_q ? ram_rdata : rdata_q;
    assign flash_valid = fvalid_q;
    assign flash_addr = faddr_q;
endmodule

// File: tb/tb_spiflash_cache.sv
// tb_spiflash_cache: directed table, corner sequences and random traffic against a line-table model.
module tb_spiflash_cache;
    logic        clk = 1'b0, reset = 1'b1, flush = 1'b0;
    logic        cpu_valid = 1'b0, cpu_instr = 1'b1;
    logic [23:0] cpu_addr = '0;
    logic [3:0]  cpu_wstrb = '0;
    logic        cpu_ready, flash_valid;
    logic [31:0] cpu_rdata;
    logic [23:0] flash_addr;
    logic        flash_ready;
    logic [31:0] flash_rdata;

    int checks = 0, fails = 0, cyc = 0, last_fr = 0, lat_cnt = 0;
    logic [23:0] fq[$];
    bit [15:0] rv;
    int rt[16];

    typedef struct {
        int op;
        logic [23:0] a;
        bit fl;
        bit hit;
    } vec_t;
    vec_t tbl[11];

    spiflash_cache dut (
        .clk(clk), .reset(reset), .flush(flush),
        .cpu_valid(cpu_valid), .cpu_instr(cpu_instr), .cpu_addr(cpu_addr), .cpu_wstrb(cpu_wstrb),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .flash_valid(flash_valid), .flash_addr(flash_addr),
        .flash_ready(flash_ready), .flash_rdata(flash_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Flash controller model: answers 3 cycles after flash_valid rises.
    initial begin
        flash_ready = 1'b0;
        flash_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                flash_ready = 1'b0;
                lat_cnt = 0;
            end else if (flash_ready) begin
                flash_ready = 1'b0;
                chk("gap", flash_valid, 1'b0);
            end else if (flash_valid) begin
                lat_cnt++;
                if (lat_cnt == 3) begin
                    flash_ready = 1'b1;
                    flash_rdata = {8'h0, flash_addr} ^ 32'hA5A5_0000;
                    fq.push_back(flash_addr);
                    last_fr = cyc;
                    lat_cnt = 0;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    function automatic logic [31:0] edata(input logic [23:0] a);
        return {8'h0, a[23:2], 2'b00} ^ 32'hA5A5_0000;
    endfunction

    function automatic bit pred(input logic [23:0] a);
        int w = int'(a) >> 2;
        return rv[(w >> 2) % 16] && rt[(w >> 2) % 16] == (w >> 6);
    endfunction

    task automatic do_req(input logic [23:0] a, input logic [3:0] ws, input bit fl,
                          output logic [31:0] rd, output int lat, output int diff, output bit ok);
        @(posedge clk);
        #1;
        fq.delete();
        cpu_addr = a;
        cpu_wstrb = ws;
        cpu_valid = 1'b1;
        if (fl) flush = 1'b1;
        lat = 0;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (fl) flush = 1'b0;
            lat++;
            if (cpu_ready) ok = 1;
        end
        rd = cpu_rdata;
        diff = cyc - last_fr;
        cpu_valid = 1'b0;
    endtask

    task automatic txn(input int op, input logic [23:0] a, input bit fl, input bit eh);
        logic [31:0] rd;
        int lat, diff, w;
        bit ok;
        if (op == 2) begin
            @(posedge clk);
            #1 flush = 1'b1;
            @(posedge clk);
            #1 flush = 1'b0;
            rv = '0;
            return;
        end
        if (fl) rv = '0;
        do_req(a, op == 1 ? 4'hF : 4'h0, fl, rd, lat, diff, ok);
        chk("done", ok, 1'b1);
        if (op == 1) begin
            chk("wr_rdata", rd, 32'h0);
            chk("wr_lat", lat, 1);
            chk("wr_flash", fq.size(), 0);
            return;
        end
        chk("rd_data", rd, edata(a));
        if (eh) begin
            chk("hit_lat", lat, 1);
            chk("hit_flash", fq.size(), 0);
        end else begin
            chk("miss_flash", fq.size(), 4);
            for (int i = 0; i < 4 && i < fq.size(); i++)
                chk("miss_addr", fq[i], {a[23:4], 4'h0} + 24'(4 * i));
            chk("miss_resp", diff, 1);
            w = int'(a) >> 2;
            rv[(w >> 2) % 16] = 1'b1;
            rt[(w >> 2) % 16] = w >> 6;
        end
    endtask

    initial begin
        logic [31:0] rd;
        int lat, diff, n, ts, ix, of, r;
        bit ok;
        tbl[0]  = '{0, 24'h100004, 1'b0, 1'b0};
        tbl[1]  = '{0, 24'h10000C, 1'b0, 1'b1};
        tbl[2]  = '{0, 24'h100104, 1'b0, 1'b0};
        tbl[3]  = '{0, 24'h100004, 1'b0, 1'b0};
        tbl[4]  = '{2, 24'h000000, 1'b0, 1'b0};
        tbl[5]  = '{0, 24'h10000C, 1'b0, 1'b0};
        tbl[6]  = '{1, 24'h100000, 1'b0, 1'b0};
        tbl[7]  = '{0, 24'h100000, 1'b0, 1'b1};
        tbl[8]  = '{0, 24'h200038, 1'b0, 1'b0};
        tbl[9]  = '{0, 24'h200030, 1'b1, 1'b0};
        tbl[10] = '{0, 24'h200030, 1'b0, 1'b1};
        rv = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", cpu_ready, 1'b0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_fvalid", flash_valid, 1'b0);
        chk("rst_faddr", flash_addr, 24'h0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) txn(tbl[i].op, tbl[i].a, tbl[i].fl, tbl[i].hit);

        // Flush pulse in the middle of a fill: data still returned, line left invalid.
        fork
            do_req(24'h300008, 4'h0, 1'b0, rd, lat, diff, ok);
            begin
                repeat (7) @(posedge clk);
                #1 flush = 1'b1;
                @(posedge clk);
                #1 flush = 1'b0;
            end
        join
        chk("ff_done", ok, 1'b1);
        chk("ff_data", rd, edata(24'h300008));
        chk("ff_flash", fq.size(), 4);
        rv = '0;
        txn(0, 24'h300008, 1'b0, 1'b0);

        // Reset after the second flash_ready of a fill.
        @(posedge clk);
        #1;
        fq.delete();
        cpu_addr = 24'h400010;
        cpu_wstrb = 4'h0;
        cpu_valid = 1'b1;
        n = 0;
        while (fq.size() < 2 && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("rf_two_words", fq.size(), 2);
        repeat (2) @(posedge clk);
        #2;
        chk("rf_inflight", flash_valid, 1'b1);
        reset = 1'b1;
        #1;
        chk("rf_fvalid", flash_valid, 1'b0);
        chk("rf_ready", cpu_ready, 1'b0);
        cpu_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        rv = '0;
        txn(0, 24'h400010, 1'b0, 1'b0);
        txn(0, 24'h400014, 1'b0, 1'b1);

        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 19);
            ts = $urandom_range(0, 2);
            ix = $urandom_range(0, 3);
            of = $urandom_range(0, 3);
            cpu_addr = 24'h100000 | 24'(ts << 8) | 24'(ix << 4) | 24'(of << 2);
            if (r < 2) txn(2, cpu_addr, 1'b0, 1'b0);
            else if (r < 5) txn(1, cpu_addr, 1'b0, 1'b0);
            else txn(0, cpu_addr, 1'b0, pred(cpu_addr));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
